// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write arbiter.
//   arb_state_e     : arbiter FSM states
//   arb_idx_width   : bits needed to index NUM_REQ requesters
//   arb_bcnt_width  : bits needed for a per-grant beat counter (0..MAX_BURST-1)
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    function automatic int unsigned arb_idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned arb_bcnt_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   i_valid  [NUM_REQ] : request vector
//   i_ptr    [IDX_W]   : last-served index; scanning starts at i_ptr+1
//   o_onehot [NUM_REQ] : winner, one-hot (0 when no request)
//   o_idx    [IDX_W]   : winner index (0 when no request)
//   o_any              : at least one request present
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    assign o_any = |i_valid;

    // Scan from farthest to nearest so the nearest valid slot after i_ptr
    // is the last write and therefore wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % 32'(NUM_REQ));
            if (i_valid[w_cand]) begin
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready requesters. A grant stays locked on one requester until
// its last beat, a valid gap, or MAX_BURST beats, then rotates.
//   clk_i, rst_i          : write clock, synchronous active-high reset
//   req_valid_i/last_i    : per-requester beat valid / last-beat flag
//   req_data_i            : packed beats, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o           : beat accepted this cycle (one-hot or 0)
//   grant_o               : registered one-hot grant, 0 when idle
//   fifo_wen_o/wdata_o    : FIFO write port (wdata is 0 when not writing)
//   fifo_full_i/werr_i    : FIFO full flag and write-error pulse
//   werr_cnt_o            : saturating count of write-error pulses
//   busy_o                : a grant is locked
// Optional (FIFO_ARB_STATS_EN): stats_clr_i and beat_cnt_o, per-requester
// saturating transfer counters; clear wins over a same-cycle increment.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 42,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          fifo_wen_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_werr_i,
    output logic [CNT_WIDTH-1:0]          werr_cnt_o,
    output logic                          busy_o
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          stats_clr_i,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  beat_cnt_o
`endif
);

    localparam int unsigned IDX_W = arb_idx_width(NUM_REQ);
    localparam int unsigned BC_W  = arb_bcnt_width(MAX_BURST);

    arb_state_e            r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_gidx;
    logic [IDX_W-1:0]      r_ptr;
    logic [BC_W-1:0]       r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_werr_cnt;

    logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
    logic [NUM_REQ-1:0]    w_pick_oh;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic                  w_valid_g;
    logic                  w_last_g;
    logic                  w_xfer;
    logic                  w_burst_end;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_valid  (req_valid_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_valid_g   = req_valid_i[r_gidx];
    assign w_last_g    = req_last_i[r_gidx];
    assign w_xfer      = (r_state == ARB_LOCK) && w_valid_g && !fifo_full_i;
    assign w_burst_end = w_last_g || (r_beat_cnt == BC_W'(MAX_BURST - 1));

    assign req_ready_o  = w_xfer ? r_grant : '0;
    assign fifo_wen_o   = w_xfer;
    assign fifo_wdata_o = w_xfer ? w_data[r_gidx] : '0;
    assign grant_o      = r_grant;
    assign busy_o       = (r_state == ARB_LOCK);
    assign werr_cnt_o   = r_werr_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_oh;
                        r_gidx     <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    // A gap releases without a transfer; a full FIFO just holds.
                    if (!w_valid_g || (w_xfer && w_burst_end)) begin
                        r_grant <= '0;
                        r_ptr   <= r_gidx;
                        r_state <= ARB_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_werr_cnt <= '0;
        end else if (fifo_werr_i && (r_werr_cnt != '1)) begin
            r_werr_cnt <= r_werr_cnt + 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_stat [NUM_REQ];

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (rst_i || stats_clr_i) begin
                r_stat[k] <= '0;
            end else if (req_ready_o[k] && (r_stat[k] != '1)) begin
                r_stat[k] <= r_stat[k] + 1'b1;
            end
        end
    end

    always_comb begin
        beat_cnt_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            beat_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = r_stat[k];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter
// against a behavioural owner/beat-count model of the arbitration rules.
// Covers FIFO_ARB_STATS_EN when that macro is defined.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 42;
    localparam int MB = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_last_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    req_ready_o;
    logic [NR-1:0]    grant_o;
    logic             fifo_wen_o;
    logic [DW-1:0]    fifo_wdata_o;
    logic             fifo_full_i;
    logic             fifo_werr_i;
    logic [CW-1:0]    werr_cnt_o;
    logic             busy_o;
    logic             clr;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*CW-1:0] beat_cnt_o;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .fifo_wen_o   (fifo_wen_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_werr_i  (fifo_werr_i),
        .werr_cnt_o   (werr_cnt_o),
        .busy_o       (busy_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr_i  (clr),
        .beat_cnt_o   (beat_cnt_o)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Requester side: pending beats per requester, and a per-cycle enable
    // used to open valid gaps.
    logic [DW-1:0] rq [NR][$];
    bit            lq [NR][$];
    bit            en [NR];

    // Observations.
    logic [DW-1:0] got[$];
    logic [DW-1:0] sent[$];
    logic [NR-1:0] ord[$];
    logic [NR-1:0] prev_grant;

    // Reference model: who holds the port, beats taken in this grant,
    // who was served last, and the counters.
    int m_owner;
    int m_beats;
    int m_lastsrv;
    int m_werr;
    int m_stats [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_beats   = 0;
        m_lastsrv = NR - 1;
        m_werr    = 0;
        for (int k = 0; k < NR; k++) m_stats[k] = 0;
    endtask

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_edge(input bit xfer);
        bit found;
        int c;
        if (rst_i) begin
            model_reset();
        end else begin
            if (fifo_werr_i && m_werr < 65535) m_werr++;
            for (int k = 0; k < NR; k++) begin
                if (clr) m_stats[k] = 0;
                else if (xfer && k == m_owner && m_stats[k] < 65535) m_stats[k]++;
            end
            if (m_owner < 0) begin
                found = 1'b0;
                for (int i = 1; i <= NR; i++) begin
                    c = (m_lastsrv + i) % NR;
                    if (!found && req_valid_i[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else if (!req_valid_i[m_owner]) begin
                m_lastsrv = m_owner;
                m_owner   = -1;
            end else if (!fifo_full_i) begin
                m_beats++;
                if (req_last_i[m_owner] || m_beats == MB) begin
                    m_lastsrv = m_owner;
                    m_owner   = -1;
                end
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() > 0) begin
                req_valid_i[k]            = en[k];
                req_data_i[k*DW +: DW]    = rq[k][0];
                req_last_i[k]             = lq[k][0];
            end else begin
                req_valid_i[k]            = 1'b0;
                req_data_i[k*DW +: DW]    = '0;
                req_last_i[k]             = 1'b0;
            end
        end
    endtask

    task automatic push_burst(input int k, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            rq[k].push_back(base + DW'(i));
            lq[k].push_back(i == len - 1);
        end
    endtask

    // One clock: drive, check every output against the model, clock, update.
    task automatic step();
        bit            x;
        logic [63:0]   e_grant, e_ready, e_data;
        logic [NR-1:0] rdy;
        drive();
        #1;
        x       = (m_owner >= 0) && req_valid_i[m_owner] && !fifo_full_i;
        e_grant = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
        e_ready = x ? (64'd1 << m_owner) : 64'd0;
        e_data  = x ? 64'(rq[m_owner][0]) : 64'd0;
        chk("grant", 64'(grant_o), e_grant);
        chk("busy", 64'(busy_o), 64'(m_owner >= 0));
        chk("ready", 64'(req_ready_o), e_ready);
        chk("wen", 64'(fifo_wen_o), 64'(x));
        chk("wdata", 64'(fifo_wdata_o), e_data);
        chk("werr_cnt", 64'(werr_cnt_o), 64'(m_werr));
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < NR; k++) chk("beat_cnt", 64'(beat_cnt_o[k*CW +: CW]), 64'(m_stats[k]));
`endif
        rdy = req_ready_o;
        if (fifo_wen_o) got.push_back(fifo_wdata_o);
        if (grant_o != '0 && grant_o != prev_grant) ord.push_back(grant_o);
        prev_grant = grant_o;
        @(posedge clk);
        model_edge(x);
        for (int k = 0; k < NR; k++) begin
            if (rdy[k] && rq[k].size() > 0) begin
                void'(rq[k].pop_front());
                void'(lq[k].pop_front());
            end
        end
        #1;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        bit busy_any;
        for (int i = 0; i < max_cyc; i++) begin
            busy_any = (m_owner >= 0);
            for (int k = 0; k < NR; k++) if (rq[k].size() > 0) busy_any = 1'b1;
            if (busy_any) step();
        end
        busy_any = (m_owner >= 0);
        for (int k = 0; k < NR; k++) if (rq[k].size() > 0) busy_any = 1'b1;
        chk(tag, 64'(busy_any), 64'd0);
    endtask

    task automatic wait_first_beat(input string tag);
        int n;
        n = 0;
        while (got.size() == 0 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(got.size()), 64'd1);
    endtask

    initial begin
        logic [NR-1:0] exp_ord [$];
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        fifo_full_i = 1'b0;
        fifo_werr_i = 1'b0;
        clr         = 1'b0;
        prev_grant  = '0;
        for (int k = 0; k < NR; k++) en[k] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();

        // Reset values.
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_werr", 64'(werr_cnt_o), 64'd0);
        chk("rst_wen", 64'(fifo_wen_o), 64'd0);
        chk("rst_wdata", 64'(fifo_wdata_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);

        // All four requesters at once: served 0,1,2,3.
        for (int k = 0; k < NR; k++) push_burst(k, 1, DW'(42'h100 * (k + 1)));
        drain("t1_drain", 40);
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        chk("t1_ord_len", 64'(ord.size()), 64'd4);
        for (int i = 0; i < 4 && i < ord.size(); i++) chk("t1_ord", 64'(ord[i]), 64'(exp_ord[i]));

        // Six-beat burst from req2 is split 4 + 2, data intact and in order.
        got.delete(); ord.delete(); sent.delete();
        push_burst(2, 6, 42'h2_0000_0000);
        for (int i = 0; i < 6; i++) sent.push_back(42'h2_0000_0000 + DW'(i));
        drain("t2_drain", 40);
        chk("t2_cnt", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("t2_data", 64'(got[i]), 64'(sent[i]));
        chk("t2_ord_len", 64'(ord.size()), 64'd2);

        // FIFO full for five cycles in the middle of a burst.
        got.delete(); ord.delete(); sent.delete();
        push_burst(0, 3, 42'h3_0000_0000);
        for (int i = 0; i < 3; i++) sent.push_back(42'h3_0000_0000 + DW'(i));
        wait_first_beat("t3_first");
        fifo_full_i = 1'b1;
        repeat (5) begin
            step();
            chk("t3_nowen", 64'(fifo_wen_o), 64'd0);
            chk("t3_hold", 64'(grant_o), 64'd1);
        end
        fifo_full_i = 1'b0;
        drain("t3_drain", 40);
        chk("t3_cnt", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t3_data", 64'(got[i]), 64'(sent[i]));

        // req1 opens a gap while req3 waits: req1, req3, then req1 again.
        got.delete(); ord.delete();
        push_burst(1, 4, 42'h1_0000_0000);
        push_burst(3, 1, 42'h3_3333_3333);
        wait_first_beat("t4_first");
        en[1] = 1'b0;
        step();
        en[1] = 1'b1;
        drain("t4_drain", 40);
        exp_ord = '{4'b0010, 4'b1000, 4'b0010};
        chk("t4_ord_len", 64'(ord.size()), 64'd3);
        for (int i = 0; i < 3 && i < ord.size(); i++) chk("t4_ord", 64'(ord[i]), 64'(exp_ord[i]));
        chk("t4_cnt", 64'(got.size()), 64'd5);

        // Write-error counter: three pulses, then saturation.
        fifo_werr_i = 1'b1;
        repeat (3) step();
        fifo_werr_i = 1'b0;
        step();
        chk("t5_werr3", 64'(werr_cnt_o), 64'd3);
        fifo_werr_i = 1'b1;
        for (int i = 0; i < 65532; i++) @(posedge clk);
        #1;
        m_werr = (m_werr + 65532 > 65535) ? 65535 : m_werr + 65532;
        fifo_werr_i = 1'b0;
        chk("t5_sat", 64'(werr_cnt_o), 64'hFFFF);
        fifo_werr_i = 1'b1;
        repeat (3) step();
        fifo_werr_i = 1'b0;
        step();
        chk("t5_stay", 64'(werr_cnt_o), 64'hFFFF);

`ifdef FIFO_ARB_STATS_EN
        // Per-requester beat counters and clear-over-increment priority.
        clr = 1'b1;
        step();
        clr = 1'b0;
        push_burst(0, 10, 42'h5_0000_0000);
        drain("t6_drain", 60);
        chk("t6_cnt10", 64'(beat_cnt_o[0 +: CW]), 64'd10);
        push_burst(0, 2, 42'h6_0000_0000);
        for (int i = 0; i < 10 && m_owner < 0; i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_clr", 64'(beat_cnt_o[0 +: CW]), 64'd0);
        drain("t6_drain2", 20);
        chk("t6_after", 64'(beat_cnt_o[0 +: CW]), 64'd1);
`endif

        // Randomized traffic with gaps, full, error pulses, clears and resets.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NR; k++) begin
                if (rq[k].size() == 0 && $urandom_range(0, 3) == 0)
                    push_burst(k, int'($urandom_range(1, 7)), DW'({k[3:0], 8'(n), 16'($urandom)}) << 8);
                en[k] = ($urandom_range(0, 9) != 0);
            end
            fifo_full_i = ($urandom_range(0, 4) == 0);
            fifo_werr_i = ($urandom_range(0, 19) == 0);
            clr         = ($urandom_range(0, 29) == 0);
            rst_i       = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_i       = 1'b0;
        clr         = 1'b0;
        fifo_full_i = 1'b0;
        fifo_werr_i = 1'b0;
        for (int k = 0; k < NR; k++) en[k] = 1'b1;
        drain("rand_drain", 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
